slon5_scan_decoder: RTL

- Receive-side counterpart of the slon5 segment/digit-select display driver.
- Samples the multiplexed segment bus and digit-select bus.
- Filters scan transitions, decodes each segment pattern back to a hex nibble, and assembles a full multi-digit frame.
- Used as an in-fabric loopback monitor for self-check of the display path and by the test harness.

---
 rtl/slon5_scan_decoder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/slon5_scan_decoder.sv
// Loopback monitor for the slon5 multiplexed display path. Seg/sel buses are
// synchronized and then filtered for stability. Each accepted scan step is
// decoded from 7-segment back to a hex nibble, and the digits are assembled
// into a full frame.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   seg_in       segment bus (bit 7 = dp, bits 6..0 = g..a), async to clk
//   sel_in       one-hot digit select, async to clk
//   frame_data   decoded nibbles, digit i at [4i+3:4i]
//   frame_dp     decimal point per digit
//   frame_err    per digit, pattern not in decode table
//   frame_vld    one-cycle pulse when frame_* update
//   stale        no valid accept for TIMEOUT cycles
module slon5_scan_decoder #(
    parameter int unsigned NDIG          = 4,
    parameter int unsigned SEG_W         = 8,
    parameter bit          SEG_ACT_HIGH  = 1'b1,
    parameter bit          SEL_ACT_HIGH  = 1'b1,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEG_W-1:0]    seg_in,
    input  logic [NDIG-1:0]     sel_in,
    output logic [4*NDIG-1:0]   frame_data,
    output logic [NDIG-1:0]     frame_dp,
    output logic [NDIG-1:0]     frame_err,
    output logic                frame_vld,
    output logic                stale
);

    localparam int unsigned SC_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [SEG_W-1:0]  seg_s1_q, seg_s2_q, held_seg_q, held_seg_d;
    logic [NDIG-1:0]   sel_s1_q, sel_s2_q, held_sel_q, held_sel_d;
    logic [SC_W-1:0]   stable_cnt_q, stable_cnt_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [4*NDIG-1:0] nib_q, nib_d, frame_data_d;
    logic [NDIG-1:0]   dp_q, dp_d, err_q, err_d, seen_q, seen_d;
    logic [NDIG-1:0]   frame_dp_d, frame_err_d;
    logic              frame_vld_d, stale_d;

    logic [SEG_W-1:0]  seg_c;
    logic [NDIG-1:0]   sel_c;
    logic              pair_eq_c, accept_c, valid_acc_c, dec_err_c;
    logic [3:0]        dec_nib_c;

    // Polarity normalization after the synchronizers
    assign seg_c = SEG_ACT_HIGH ? seg_s2_q : ~seg_s2_q;
    assign sel_c = SEL_ACT_HIGH ? sel_s2_q : ~sel_s2_q;

    // Accept fires once per stable pair: the counter saturates past the match value
    assign pair_eq_c   = (seg_c == held_seg_q) && (sel_c == held_sel_q);
    assign accept_c    = pair_eq_c && (stable_cnt_q == SC_W'(STABLE_CYCLES - 1));
    assign valid_acc_c = accept_c && $onehot(sel_c);

    // 7-segment to hex; unknown patterns decode to 0 with error
    always_comb begin
        dec_nib_c = 4'h0;
        dec_err_c = 1'b0;
        case (seg_c[6:0])
            7'h3F: dec_nib_c = 4'h0;
            7'h06: dec_nib_c = 4'h1;
            7'h5B: dec_nib_c = 4'h2;
            7'h4F: dec_nib_c = 4'h3;
            7'h66: dec_nib_c = 4'h4;
            7'h6D: dec_nib_c = 4'h5;
            7'h7D: dec_nib_c = 4'h6;
            7'h07: dec_nib_c = 4'h7;
            7'h7F: dec_nib_c = 4'h8;
            7'h6F: dec_nib_c = 4'h9;
            7'h77: dec_nib_c = 4'hA;
            7'h7C: dec_nib_c = 4'hB;
            7'h39: dec_nib_c = 4'hC;
            7'h5E: dec_nib_c = 4'hD;
            7'h79: dec_nib_c = 4'hE;
            7'h71: dec_nib_c = 4'hF;
            default: dec_err_c = 1'b1;
        endcase
    end

    // Next-state: filter, digit write, frame completion, watchdog
    always_comb begin
        held_seg_d   = held_seg_q;
        held_sel_d   = held_sel_q;
        stable_cnt_d = stable_cnt_q;
        nib_d        = nib_q;
        dp_d         = dp_q;
        err_d        = err_q;
        seen_d       = seen_q;
        wdog_d       = wdog_q;
        stale_d      = stale;
        frame_data_d = frame_data;
        frame_dp_d   = frame_dp;
        frame_err_d  = frame_err;
        frame_vld_d  = 1'b0;

        if (!pair_eq_c) begin
            held_seg_d   = seg_c;
            held_sel_d   = sel_c;
            stable_cnt_d = '0;
        end else if (stable_cnt_q != SC_W'(STABLE_CYCLES)) begin
            stable_cnt_d = stable_cnt_q + SC_W'(1);
        end

        if (valid_acc_c) begin
            wdog_d  = '0;
            stale_d = 1'b0;
        end else if (wdog_q != WD_W'(TIMEOUT)) begin
            wdog_d = wdog_q + WD_W'(1);
            if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                stale_d = 1'b1;
                seen_d  = '0;
            end
        end

        if (valid_acc_c) begin
            for (int i = 0; i < int'(NDIG); i++) begin
                if (sel_c[i]) begin
                    nib_d[4*i +: 4] = dec_nib_c;
                    dp_d[i]         = seg_c[7];
                    err_d[i]        = dec_err_c;
                end
            end
            // Frame publishes including the digit written on this same edge
            if ((seen_q | sel_c) == {NDIG{1'b1}}) begin
                frame_data_d = nib_d;
                frame_dp_d   = dp_d;
                frame_err_d  = err_d;
                frame_vld_d  = 1'b1;
                seen_d       = '0;
            end else begin
                seen_d = seen_q | sel_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q     <= '0;
            seg_s2_q     <= '0;
            sel_s1_q     <= '0;
            sel_s2_q     <= '0;
            held_seg_q   <= '0;
            held_sel_q   <= '0;
            stable_cnt_q <= '0;
            nib_q        <= '0;
            dp_q         <= '0;
            err_q        <= '0;
            seen_q       <= '0;
            wdog_q       <= '0;
            stale        <= 1'b0;
            frame_data   <= '0;
            frame_dp     <= '0;
            frame_err    <= '0;
            frame_vld    <= 1'b0;
        end else begin
            seg_s1_q     <= seg_in;
            seg_s2_q     <= seg_s1_q;
            sel_s1_q     <= sel_in;
            sel_s2_q     <= sel_s1_q;
            held_seg_q   <= held_seg_d;
            held_sel_q   <= held_sel_d;
            stable_cnt_q <= stable_cnt_d;
            nib_q        <= nib_d;
            dp_q         <= dp_d;
            err_q        <= err_d;
            seen_q       <= seen_d;
            wdog_q       <= wdog_d;
            stale        <= stale_d;
            frame_data   <= frame_data_d;
            frame_dp     <= frame_dp_d;
            frame_err    <= frame_err_d;
            frame_vld    <= frame_vld_d;
        end
    end

endmodule
